memq_sched: RTL and testbench

In-order scheduler for the RAM functional unit. It buffers memory ops from dispatch in a small circular queue and snoops the CDB to resolve pending address and data operands. It issues the oldest op to the RAM FU only when that op's operands are ready and the FU is idle. Program order of loads and stores is preserved, because the RAM FU writes its array at issue, not at commit.

---
 rtl/memq_pkg.sv | 20 ++
 rtl/memq_slot.sv | 49 ++++
 rtl/memq_sched.sv | 118 +++++++++++
 tb/tb_memq_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/memq_pkg.sv
// Shared types and widths for the RAM-unit in-order scheduler.
package memq_pkg;
    localparam int ROBID_W        = 4;
    localparam int DATA_W         = 8;
    localparam int STORE_FLAG_BIT = 1;

    typedef struct packed {
        logic [ROBID_W-1:0] robid;
        logic [DATA_W-1:0]  operand;
        logic [DATA_W-1:0]  wbs;
        logic [DATA_W-1:0]  flags;
        logic [DATA_W-1:0]  val_a;
        logic [DATA_W-1:0]  val_b;
        logic [ROBID_W-1:0] tag_a;
        logic [ROBID_W-1:0] tag_b;
        logic               rdy_a;
        logic               rdy_b;
        logic               valid;
    } memq_entry_t;
endpackage

// File: rtl/memq_slot.sv
// One scheduler entry: loads from dispatch, captures pending operands off the CDB.
module memq_slot
    import memq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_load,
    input  memq_entry_t         i_entry,
    input  logic                i_cdb_valid,
    input  logic [ROBID_W-1:0]  i_cdb_id,
    input  logic [DATA_W-1:0]   i_cdb_val,
    output memq_entry_t         o_entry
);
    memq_entry_t r_entry;

    function automatic memq_entry_t snoop(input memq_entry_t e, input logic cv,
                                          input logic [ROBID_W-1:0] cid,
                                          input logic [DATA_W-1:0] cval);
        memq_entry_t s;
        s = e;
        if (e.valid && cv && !e.rdy_a && e.tag_a == cid) begin
            s.val_a = cval;
            s.rdy_a = 1'b1;
        end
        if (e.valid && cv && !e.rdy_b && e.tag_b == cid) begin
            s.val_b = cval;
            s.rdy_b = 1'b1;
        end
        return s;
    endfunction

    // An incoming op sees the same-cycle broadcast too (enqueue bypass).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_entry <= '0;
        end else if (i_clear) begin
            r_entry.valid <= 1'b0;
            r_entry.rdy_a <= 1'b0;
            r_entry.rdy_b <= 1'b0;
        end else if (i_load) begin
            r_entry <= snoop(i_entry, i_cdb_valid, i_cdb_id, i_cdb_val);
        end else begin
            r_entry <= snoop(r_entry, i_cdb_valid, i_cdb_id, i_cdb_val);
        end
    end

    assign o_entry = r_entry;
endmodule

// File: rtl/memq_sched.sv
// In-order RAM-unit scheduler: circular queue, CDB snoop, head-only issue.
module memq_sched
    import memq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [3:0]                enq_robid,
    input  logic [7:0]                enq_operand,
    input  logic [7:0]                enq_wbs,
    input  logic [7:0]                enq_flags,
    input  logic [7:0]                enq_val_a,
    input  logic [7:0]                enq_val_b,
    input  logic                      enq_rdy_a,
    input  logic                      enq_rdy_b,
    input  logic [3:0]                enq_tag_a,
    input  logic [3:0]                enq_tag_b,
    input  logic                      cdb_valid,
    input  logic [3:0]                cdb_id,
    input  logic [7:0]                cdb_val,
    input  logic                      fu_busy,
    output logic                      fu_transmit,
    output logic [3:0]                fu_robid,
    output logic [7:0]                fu_operand,
    output logic [7:0]                fu_wbs,
    output logic [7:0]                fu_flags,
    output logic [1:0][7:0]           fu_depvals,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W:0]   r_head;
    logic [IDX_W:0]   r_tail;
    logic             w_full;
    logic             w_enq;
    logic             w_issue;
    memq_entry_t      w_enq_entry;
    memq_entry_t      w_slots [DEPTH];
    memq_entry_t      w_head;

    // Wrap bits distinguish full from empty when the indices coincide.
    assign w_full    = (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]) && (r_head[IDX_W] != r_tail[IDX_W]);
    assign enq_ready = !w_full;
    assign w_enq     = enq_valid && !w_full;
    assign count     = r_tail - r_head;
    assign w_head    = w_slots[r_head[IDX_W-1:0]];
    assign w_issue   = w_head.valid && w_head.rdy_a && w_head.rdy_b && !fu_busy && !fu_transmit;

    always_comb begin
        w_enq_entry         = '0;
        w_enq_entry.robid   = enq_robid;
        w_enq_entry.operand = enq_operand;
        w_enq_entry.wbs     = enq_wbs;
        w_enq_entry.flags   = enq_flags;
        w_enq_entry.val_a   = enq_val_a;
        w_enq_entry.val_b   = enq_val_b;
        w_enq_entry.tag_a   = enq_tag_a;
        w_enq_entry.tag_b   = enq_tag_b;
        w_enq_entry.rdy_a   = enq_rdy_a;
        w_enq_entry.rdy_b   = enq_rdy_b || !enq_flags[STORE_FLAG_BIT];
        w_enq_entry.valid   = 1'b1;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic w_clear;
        logic w_load;
        logic w_unused_tags;
        assign w_clear = flush || (w_issue && r_head[IDX_W-1:0] == IDX_W'(g));
        assign w_load  = w_enq && r_tail[IDX_W-1:0] == IDX_W'(g);
        assign w_unused_tags = ^{w_slots[g].tag_a, w_slots[g].tag_b};

        memq_slot u_slot (
            .clk         (clk),
            .rst         (rst),
            .i_clear     (w_clear),
            .i_load      (w_load),
            .i_entry     (w_enq_entry),
            .i_cdb_valid (cdb_valid),
            .i_cdb_id    (cdb_id),
            .i_cdb_val   (cdb_val),
            .o_entry     (w_slots[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            fu_transmit <= 1'b0;
            fu_robid    <= '0;
            fu_operand  <= '0;
            fu_wbs      <= '0;
            fu_flags    <= '0;
            fu_depvals  <= '0;
        end else if (flush) begin
            r_head      <= '0;
            r_tail      <= '0;
            fu_transmit <= 1'b0;
        end else begin
            fu_transmit <= w_issue;
            if (w_enq)
                r_tail <= r_tail + 1'b1;
            if (w_issue) begin
                r_head        <= r_head + 1'b1;
                fu_robid      <= w_head.robid;
                fu_operand    <= w_head.operand;
                fu_wbs        <= w_head.wbs;
                fu_flags      <= w_head.flags;
                fu_depvals[0] <= w_head.val_a;
                fu_depvals[1] <= w_head.val_b;
            end
        end
    end
endmodule

// File: tb/tb_memq_sched.sv
// Directed bench for memq_sched with hand-computed expectations.
module tb_memq_sched;
    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           flush = 1'b0;
    logic           enq_valid = 1'b0;
    logic           enq_ready;
    logic [3:0]     enq_robid = '0;
    logic [7:0]     enq_operand = '0, enq_wbs = '0, enq_flags = '0;
    logic [7:0]     enq_val_a = '0, enq_val_b = '0;
    logic           enq_rdy_a = 1'b0, enq_rdy_b = 1'b0;
    logic [3:0]     enq_tag_a = '0, enq_tag_b = '0;
    logic           cdb_valid = 1'b0;
    logic [3:0]     cdb_id = '0;
    logic [7:0]     cdb_val = '0;
    logic           fu_busy = 1'b0;
    logic           fu_transmit;
    logic [3:0]     fu_robid;
    logic [7:0]     fu_operand, fu_wbs, fu_flags;
    logic [1:0][7:0] fu_depvals;
    logic [2:0]     count;

    int checks = 0;
    int errors = 0;

    memq_sched #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_robid(enq_robid),
        .enq_operand(enq_operand), .enq_wbs(enq_wbs), .enq_flags(enq_flags),
        .enq_val_a(enq_val_a), .enq_val_b(enq_val_b),
        .enq_rdy_a(enq_rdy_a), .enq_rdy_b(enq_rdy_b),
        .enq_tag_a(enq_tag_a), .enq_tag_b(enq_tag_b),
        .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val),
        .fu_busy(fu_busy), .fu_transmit(fu_transmit), .fu_robid(fu_robid),
        .fu_operand(fu_operand), .fu_wbs(fu_wbs), .fu_flags(fu_flags),
        .fu_depvals(fu_depvals), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] robid, input logic [7:0] flags,
                          input logic [7:0] va, input logic ra, input logic [3:0] ta,
                          input logic [7:0] vb, input logic rb, input logic [3:0] tb);
        enq_valid = 1'b1;
        enq_robid = robid;
        enq_operand = {4'h5, robid};
        enq_wbs = {4'h6, robid};
        enq_flags = flags;
        enq_val_a = va; enq_rdy_a = ra; enq_tag_a = ta;
        enq_val_b = vb; enq_rdy_b = rb; enq_tag_b = tb;
    endtask

    initial begin
        #2;
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);
        chk("rst_transmit", 32'(fu_transmit), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_robid", 32'(fu_robid), 32'd0);
        chk("rst_depvals", 32'(fu_depvals), 32'd0);
        step();
        rst = 1'b1;
        step();

        // Ready load; B left not ready must be forced ready for a load.
        set_op(4'd3, 8'h00, 8'h10, 1'b1, 4'd0, 8'h00, 1'b0, 4'd9);
        step();
        enq_valid = 1'b0;
        chk("t1_count_after_enq", 32'(count), 32'd1);
        chk("t1_no_tx_at_enq", 32'(fu_transmit), 32'd0);
        step();
        chk("t1_tx", 32'(fu_transmit), 32'd1);
        chk("t1_robid", 32'(fu_robid), 32'd3);
        chk("t1_dep_a", 32'(fu_depvals[0]), 32'h10);
        chk("t1_operand", 32'(fu_operand), 32'h53);
        chk("t1_wbs", 32'(fu_wbs), 32'h63);
        chk("t1_count", 32'(count), 32'd0);
        step();
        chk("t1_tx_one_cycle", 32'(fu_transmit), 32'd0);
        chk("t1_robid_hold", 32'(fu_robid), 32'd3);

        // Order and snoop: store waiting on tag 5 blocks the ready load behind it.
        set_op(4'd1, 8'h02, 8'h00, 1'b0, 4'd5, 8'h77, 1'b1, 4'd0);
        step();
        set_op(4'd2, 8'h00, 8'h30, 1'b1, 4'd0, 8'h00, 1'b1, 4'd0);
        step();
        enq_valid = 1'b0;
        chk("t2_count2", 32'(count), 32'd2);
        chk("t2_no_tx_a", 32'(fu_transmit), 32'd0);
        step();
        chk("t2_no_tx_b", 32'(fu_transmit), 32'd0);
        cdb_valid = 1'b1; cdb_id = 4'd5; cdb_val = 8'h20;
        step();
        cdb_valid = 1'b0;
        chk("t2_no_tx_at_capture", 32'(fu_transmit), 32'd0);
        step();
        chk("t2_store_tx", 32'(fu_transmit), 32'd1);
        chk("t2_store_robid", 32'(fu_robid), 32'd1);
        chk("t2_store_depvals", 32'(fu_depvals), 32'h7720);
        chk("t2_store_flags", 32'(fu_flags), 32'h02);
        step();
        chk("t2_gap", 32'(fu_transmit), 32'd0);
        chk("t2_count1", 32'(count), 32'd1);
        step();
        chk("t2_load_tx", 32'(fu_transmit), 32'd1);
        chk("t2_load_robid", 32'(fu_robid), 32'd2);
        chk("t2_load_dep_a", 32'(fu_depvals[0]), 32'h30);
        chk("t2_count0", 32'(count), 32'd0);
        step();

        // Enqueue bypass on B.
        set_op(4'd4, 8'h02, 8'h40, 1'b1, 4'd0, 8'h00, 1'b0, 4'd7);
        cdb_valid = 1'b1; cdb_id = 4'd7; cdb_val = 8'hAB;
        step();
        enq_valid = 1'b0; cdb_valid = 1'b0;
        step();
        chk("t3_tx", 32'(fu_transmit), 32'd1);
        chk("t3_robid", 32'(fu_robid), 32'd4);
        chk("t3_depvals", 32'(fu_depvals), 32'hAB40);
        step();

        // Fill to full while the FU is busy, then drain and cross the wrap.
        fu_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(4'(8 + i), 8'h00, 8'(8'h80 + i), 1'b1, 4'd0, 8'h00, 1'b1, 4'd0);
            step();
        end
        chk("t4_full_ready", 32'(enq_ready), 32'd0);
        chk("t4_full_count", 32'(count), 32'd4);
        set_op(4'd12, 8'h00, 8'hEE, 1'b1, 4'd0, 8'h00, 1'b1, 4'd0);
        step();
        enq_valid = 1'b0;
        chk("t4_full_hold_count", 32'(count), 32'd4);
        chk("t4_busy_no_tx", 32'(fu_transmit), 32'd0);
        fu_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t4_drain_tx%0d", i), 32'(fu_transmit), 32'd1);
            chk($sformatf("t4_drain_robid%0d", i), 32'(fu_robid), 32'(8 + i));
            chk($sformatf("t4_drain_a%0d", i), 32'(fu_depvals[0]), 32'(8'h80 + i));
            step();
            chk($sformatf("t4_drain_gap%0d", i), 32'(fu_transmit), 32'd0);
        end
        chk("t4_empty_count", 32'(count), 32'd0);
        for (int i = 0; i < 6; i++) begin
            set_op(4'(i), 8'h00, 8'(8'hC0 + i), 1'b1, 4'd0, 8'h00, 1'b1, 4'd0);
            step();
            enq_valid = 1'b0;
            step();
            chk($sformatf("t4_wrap_tx%0d", i), 32'(fu_transmit), 32'd1);
            chk($sformatf("t4_wrap_robid%0d", i), 32'(fu_robid), 32'(i));
            chk($sformatf("t4_wrap_a%0d", i), 32'(fu_depvals[0]), 32'(8'hC0 + i));
            step();
        end
        chk("t4_wrap_count", 32'(count), 32'd0);

        // Flush beats an eligible issue in the same cycle.
        fu_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(4'(1 + i), 8'h00, 8'h11, 1'b1, 4'd0, 8'h00, 1'b1, 4'd0);
            step();
        end
        enq_valid = 1'b0;
        chk("t5_count3", 32'(count), 32'd3);
        fu_busy = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_no_tx", 32'(fu_transmit), 32'd0);
        chk("t5_count0", 32'(count), 32'd0);
        chk("t5_enq_ready", 32'(enq_ready), 32'd1);
        step();
        chk("t5_still_no_tx", 32'(fu_transmit), 32'd0);

        // Asynchronous reset while fu_transmit is high.
        set_op(4'd6, 8'h00, 8'h66, 1'b1, 4'd0, 8'h00, 1'b1, 4'd0);
        step();
        enq_valid = 1'b0;
        step();
        chk("t6_tx_before_rst", 32'(fu_transmit), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_tx", 32'(fu_transmit), 32'd0);
        chk("t6_robid", 32'(fu_robid), 32'd0);
        chk("t6_operand", 32'(fu_operand), 32'd0);
        chk("t6_wbs", 32'(fu_wbs), 32'd0);
        chk("t6_flags", 32'(fu_flags), 32'd0);
        chk("t6_depvals", 32'(fu_depvals), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_enq_ready", 32'(enq_ready), 32'd1);
        rst = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
